// File: rtl/rupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : rupt_controller
// Purpose  : Interrupt arbiter between the memory-block flag register and the
//            CPU sequencer. Picks the highest-priority pending source, presents
//            its AGC vector with a request/ack handshake, pulses the matching
//            interrupt_clear bit and supervises RUPT LOCK (ISR overrun) and
//            starvation (no interrupt taken for too long).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            interrupt_flags[5:0] - pending sources (T3,T4,T5,T6,KEY1,KEY2)
//            rupt_inhibit         - blocks new selection
//            rupt_ack             - CPU took the vector (REQUEST only)
//            rupt_resume          - CPU executed RESUME (ACTIVE only)
//            alarm_clear          - clears both sticky alarms and counters
//            interrupt_clear[5:0] - one-hot one-cycle clear pulse
//            rupt_request         - vector valid
//            rupt_vector[11:0]    - entry address
//            in_rupt              - high while servicing
//            lock_alarm           - sticky ISR overrun alarm
//            starve_alarm         - sticky starvation alarm
// Revision : 1.0 - initial release
// ============================================================================
module rupt_controller #(
  parameter int LOCK_CYCLES = 840000,
  parameter int IDLE_CYCLES = 840000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  interrupt_flags,
  input  logic        rupt_inhibit,
  input  logic        rupt_ack,
  input  logic        rupt_resume,
  input  logic        alarm_clear,
  output logic [5:0]  interrupt_clear,
  output logic        rupt_request,
  output logic [11:0] rupt_vector,
  output logic        in_rupt,
  output logic        lock_alarm,
  output logic        starve_alarm
);

  localparam logic [23:0] LOCK_MAX = 24'(LOCK_CYCLES - 1);
  localparam logic [23:0] IDLE_MAX = 24'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_ACTIVE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_sel_idx;
  logic [2:0]  w_win_idx;
  logic [11:0] w_win_vec;
  logic        w_take;
  logic        w_accept;
  logic        w_leave;
  logic [23:0] r_lock_cnt;
  logic [23:0] r_starve_cnt;

  // Fixed priority: T6, T5, T3, T4, KEY1, KEY2.
  always_comb begin
    w_win_idx = 3'd0;
    w_win_vec = 12'o0000;
    if (interrupt_flags[3]) begin
      w_win_idx = 3'd3; w_win_vec = 12'o4004;
    end else if (interrupt_flags[2]) begin
      w_win_idx = 3'd2; w_win_vec = 12'o4010;
    end else if (interrupt_flags[0]) begin
      w_win_idx = 3'd0; w_win_vec = 12'o4014;
    end else if (interrupt_flags[1]) begin
      w_win_idx = 3'd1; w_win_vec = 12'o4020;
    end else if (interrupt_flags[4]) begin
      w_win_idx = 3'd4; w_win_vec = 12'o4024;
    end else if (interrupt_flags[5]) begin
      w_win_idx = 3'd5; w_win_vec = 12'o4030;
    end
  end

  assign w_take   = (r_state == S_IDLE) && !rupt_inhibit && (interrupt_flags != 6'd0);
  assign w_accept = (r_state == S_REQUEST) && rupt_ack;
  assign w_leave  = (r_state == S_ACTIVE) && rupt_resume;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_take)   w_next_state = S_REQUEST;
      S_REQUEST: if (w_accept) w_next_state = S_ACTIVE;
      S_ACTIVE:  if (w_leave)  w_next_state = S_IDLE;
      default:                 w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs. The vector and winner index are latched only on
  // selection, so they stay frozen for the whole REQUEST phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_clear <= 6'd0;
      rupt_request    <= 1'b0;
      rupt_vector     <= 12'o0000;
      in_rupt         <= 1'b0;
      r_sel_idx       <= 3'd0;
    end else begin
      interrupt_clear <= 6'd0;
      if (w_take) begin
        rupt_request <= 1'b1;
        rupt_vector  <= w_win_vec;
        r_sel_idx    <= w_win_idx;
      end
      if (w_accept) begin
        rupt_request    <= 1'b0;
        interrupt_clear <= 6'b000001 << r_sel_idx;
        in_rupt         <= 1'b1;
      end
      if (w_leave) in_rupt <= 1'b0;
    end
  end

  // Supervision counters. The alarm is raised on the cycle after the counter
  // has reached its limit, and the counter then holds there.
  always_ff @(posedge clk) begin
    if (reset || alarm_clear) begin
      r_lock_cnt   <= 24'd0;
      r_starve_cnt <= 24'd0;
      lock_alarm   <= 1'b0;
      starve_alarm <= 1'b0;
    end else begin
      if (r_state == S_ACTIVE) begin
        if (r_lock_cnt == LOCK_MAX) lock_alarm <= 1'b1;
        else                        r_lock_cnt <= r_lock_cnt + 24'd1;
      end else begin
        r_lock_cnt <= 24'd0;
      end

      if (w_accept)                     r_starve_cnt <= 24'd0;
      else if (r_starve_cnt == IDLE_MAX) starve_alarm <= 1'b1;
      else                              r_starve_cnt <= r_starve_cnt + 24'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rupt_controller
// Purpose  : Self-checking bench for rupt_controller. A reference model turns
//            the arbitration rules into expected outputs and queued
//            vector/clear events; a monitor compares them with the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rupt_controller;

  localparam int LOCK = 16;
  localparam int IDLE = 32;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ACT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  flags;
  logic        rupt_inhibit;
  logic        rupt_ack;
  logic        rupt_resume;
  logic        alarm_clear;
  logic [5:0]  interrupt_clear;
  logic        rupt_request;
  logic [11:0] rupt_vector;
  logic        in_rupt;
  logic        lock_alarm;
  logic        starve_alarm;

  always #5 clk = ~clk;

  rupt_controller #(.LOCK_CYCLES(LOCK), .IDLE_CYCLES(IDLE)) dut (
    .clk             (clk),
    .reset           (reset),
    .interrupt_flags (flags),
    .rupt_inhibit    (rupt_inhibit),
    .rupt_ack        (rupt_ack),
    .rupt_resume     (rupt_resume),
    .alarm_clear     (alarm_clear),
    .interrupt_clear (interrupt_clear),
    .rupt_request    (rupt_request),
    .rupt_vector     (rupt_vector),
    .in_rupt         (in_rupt),
    .lock_alarm      (lock_alarm),
    .starve_alarm    (starve_alarm)
  );

  // ---------------- reference model ----------------
  int          phase = P_IDLE;
  int          sel = 0;
  longint      cyc = 0;
  longint      starve_t = 0;
  longint      act_t = 0;
  logic        m_live = 1'b0;
  logic        m_after_rst = 1'b0;
  logic        m_req = 1'b0;
  logic        m_in = 1'b0;
  logic        m_lock = 1'b0;
  logic        m_starve = 1'b0;
  logic [5:0]  m_clr = 6'd0;
  logic [11:0] m_vec = 12'd0;
  logic [11:0] exp_req_q[$];
  logic [5:0]  exp_clr_q[$];

  function automatic int winner(input logic [5:0] f);
    int prio[6] = '{3, 2, 0, 1, 4, 5};
    for (int i = 0; i < 6; i++)
      if (f[prio[i]]) return prio[i];
    return -1;
  endfunction

  function automatic logic [11:0] vec_of(input int b);
    case (b)
      0:       return 12'o4014;
      1:       return 12'o4020;
      2:       return 12'o4010;
      3:       return 12'o4004;
      4:       return 12'o4024;
      default: return 12'o4030;
    endcase
  endfunction

  always @(posedge clk) begin : ref_model
    int   ph0;
    int   w;
    logic took;
    cyc++;
    m_clr = 6'd0;
    m_after_rst = 1'b0;
    if (reset) begin
      phase = P_IDLE; m_req = 1'b0; m_in = 1'b0; m_vec = 12'd0;
      m_lock = 1'b0; m_starve = 1'b0; starve_t = cyc; act_t = cyc;
      m_live = 1'b1; m_after_rst = 1'b1;
    end else if (m_live) begin
      ph0 = phase;
      took = 1'b0;
      if (phase == P_IDLE) begin
        w = winner(flags);
        if (!rupt_inhibit && w >= 0) begin
          sel = w; m_req = 1'b1; m_vec = vec_of(w);
          exp_req_q.push_back(m_vec);
          phase = P_REQ;
        end
      end else if (phase == P_REQ) begin
        if (rupt_ack) begin
          took = 1'b1; m_req = 1'b0; m_in = 1'b1;
          m_clr = 6'b000001 << sel;
          exp_clr_q.push_back(m_clr);
          phase = P_ACT; act_t = cyc;
        end
      end else if (rupt_resume) begin
        m_in = 1'b0; phase = P_IDLE;
      end
      // Alarms: sticky once the last restart point is LOCK/IDLE edges back.
      if (alarm_clear) begin
        m_lock = 1'b0; m_starve = 1'b0; starve_t = cyc; act_t = cyc;
      end else begin
        if (took) starve_t = cyc;
        else if (cyc - starve_t >= longint'(IDLE)) m_starve = 1'b1;
        if (ph0 == P_ACT && (cyc - act_t >= longint'(LOCK))) m_lock = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_timeouts = 0;
  logic done = 1'b0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [11:0] ev;
    logic [5:0]  ec;
    if (m_live) begin
      check("rupt_request", 32'(rupt_request), 32'(m_req));
      check("in_rupt", 32'(in_rupt), 32'(m_in));
      check("interrupt_clear", 32'(interrupt_clear), 32'(m_clr));
      check("lock_alarm", 32'(lock_alarm), 32'(m_lock));
      check("starve_alarm", 32'(starve_alarm), 32'(m_starve));
      if (m_req || m_after_rst) check("rupt_vector", 32'(rupt_vector), 32'(m_vec));
      if (rupt_request && !prev_req) begin
        if (exp_req_q.size() == 0) check("sb_unexpected_request", 32'(rupt_vector), 32'd0);
        else begin
          ev = exp_req_q.pop_front();
          check("sb_request_vector", 32'(rupt_vector), 32'(ev));
        end
      end
      if (interrupt_clear != 6'd0) begin
        if (exp_clr_q.size() == 0) check("sb_unexpected_clear", 32'(interrupt_clear), 32'd0);
        else begin
          ec = exp_clr_q.pop_front();
          check("sb_clear_pulse", 32'(interrupt_clear), 32'(ec));
        end
      end
    end
    prev_req = rupt_request;
    if (done) begin
      check("sb_requests_left", 32'(exp_req_q.size()), 32'd0);
      check("sb_clears_left", 32'(exp_clr_q.size()), 32'd0);
      check("wait_timeouts", 32'(n_timeouts), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  // Advances one clock; also acts as the memory block, dropping any flag the
  // DUT has just pulsed clear.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      flags = flags & ~interrupt_clear;
    end
  endtask

  task automatic wait_req(input int maxc);
    int k = 0;
    while (!rupt_request && k < maxc) begin
      cycle(1);
      k++;
    end
    if (!rupt_request) n_timeouts++;
  endtask

  task automatic episode();
    wait_req(200);
    rupt_ack = 1'b1;
    cycle(1);
    rupt_ack = 1'b0;
    cycle(2);
    rupt_resume = 1'b1;
    cycle(1);
    rupt_resume = 1'b0;
  endtask

  task automatic pulse_clear();
    alarm_clear = 1'b1;
    cycle(1);
    alarm_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flags = 6'd0; rupt_inhibit = 1'b0;
    rupt_ack = 1'b0; rupt_resume = 1'b0; alarm_clear = 1'b0;
    cycle(3);
    reset = 1'b0;
    cycle(2);

    // Single T3 source.
    flags = 6'b000001;
    episode();
    cycle(3);

    // Three simultaneous sources serviced in priority order.
    flags = 6'b001011;
    repeat (3) episode();
    cycle(3);

    // Inhibited KEY1, then a higher-priority arrival during REQUEST.
    pulse_clear();
    flags = 6'b010000;
    rupt_inhibit = 1'b1;
    cycle(50);
    rupt_inhibit = 1'b0;
    cycle(1);
    flags = flags | 6'b001000;
    cycle(3);
    episode();
    episode();
    cycle(3);

    // ISR overrun.
    pulse_clear();
    flags = 6'b000001;
    wait_req(50);
    rupt_ack = 1'b1;
    cycle(1);
    rupt_ack = 1'b0;
    cycle(20);
    pulse_clear();
    cycle(2);
    rupt_resume = 1'b1;
    cycle(1);
    rupt_resume = 1'b0;

    // Starvation, then an ack inside the window keeps it quiet.
    pulse_clear();
    flags = 6'd0;
    cycle(40);
    pulse_clear();
    cycle(8);
    flags = 6'b100000;
    episode();
    cycle(15);

    // Reset during REQUEST, then during ACTIVE, followed by stale handshakes.
    flags = 6'b000001;
    wait_req(50);
    flags = 6'd0;
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    rupt_ack = 1'b1; rupt_resume = 1'b1;
    cycle(3);
    rupt_ack = 1'b0; rupt_resume = 1'b0;
    flags = 6'b000010;
    wait_req(50);
    rupt_ack = 1'b1;
    cycle(1);
    rupt_ack = 1'b0;
    cycle(2);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    rupt_ack = 1'b1; rupt_resume = 1'b1;
    cycle(3);
    rupt_ack = 1'b0; rupt_resume = 1'b0;
    cycle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) flags = flags | 6'($urandom_range(1, 63));
      rupt_inhibit = ($urandom_range(0, 3) == 0);
      rupt_ack     = ($urandom_range(0, 1) == 0);
      rupt_resume  = ($urandom_range(0, 3) == 0);
      alarm_clear  = ($urandom_range(0, 63) == 0);
      reset        = ($urandom_range(0, 399) == 0);
      cycle(1);
    end
    reset = 1'b0; rupt_inhibit = 1'b0; rupt_ack = 1'b0;
    rupt_resume = 1'b0; alarm_clear = 1'b0; flags = 6'd0;
    cycle(5);
    done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
